// File: rtl/npu_cube_pkg.sv
`default_nettype none
// ============================================================================
// Module : npu_cube_pkg
// Brief  : Shared widths and state encoding for the NPU cube add-tree datapath.
// Rev    : 1.0 - initial release
// ============================================================================
package npu_cube_pkg;

    localparam int DWA              = 8;
    localparam int DWB_CODE         = 12;
    localparam int NPU_CUBE_MAC_NUM = 8;
    localparam int DWOUPUT          = 19;
    localparam int DWACC            = 32;
    localparam int DWLEN            = 16;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd1;
    localparam logic [STATE_W-1:0] ST_DRAIN = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/npu_cube_acc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : npu_cube_acc_ctrl_if
// Brief  : Config, operand, add-tree and result signals of the cube accumulator.
// Rev    : 1.0 - initial release
// ============================================================================
interface npu_cube_acc_ctrl_if #(
    parameter int DWA              = npu_cube_pkg::DWA,
    parameter int DWB_CODE         = npu_cube_pkg::DWB_CODE,
    parameter int NPU_CUBE_MAC_NUM = npu_cube_pkg::NPU_CUBE_MAC_NUM,
    parameter int DWOUPUT          = npu_cube_pkg::DWOUPUT,
    parameter int DWACC            = npu_cube_pkg::DWACC,
    parameter int DWLEN            = npu_cube_pkg::DWLEN
);
    logic                                 cfg_start;
    logic [DWLEN-1:0]                     cfg_len;
    logic                                 cfg_signed;
    logic                                 cfg_busy;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [DWA*NPU_CUBE_MAC_NUM-1:0]      in_data;
    logic [DWB_CODE*NPU_CUBE_MAC_NUM-1:0] in_para_code;
    logic [DWA*NPU_CUBE_MAC_NUM-1:0]      tree_data;
    logic [DWB_CODE*NPU_CUBE_MAC_NUM-1:0] tree_para_code;
    logic                                 tree_is_signed;
    logic [DWOUPUT-1:0]                   tree_result_s;
    logic [DWOUPUT-1:0]                   tree_result_c;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [DWACC-1:0]                     out_acc;
    logic                                 out_ovf;

    modport master (
        output cfg_start, cfg_len, cfg_signed, in_valid, in_data, in_para_code,
               tree_result_s, tree_result_c, out_ready,
        input  cfg_busy, in_ready, tree_data, tree_para_code, tree_is_signed,
               out_valid, out_acc, out_ovf
    );

    modport slave (
        input  cfg_start, cfg_len, cfg_signed, in_valid, in_data, in_para_code,
               tree_result_s, tree_result_c, out_ready,
        output cfg_busy, in_ready, tree_data, tree_para_code, tree_is_signed,
               out_valid, out_acc, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/npu_cube_cs_resolve.sv
`default_nettype none
// ============================================================================
// Module : npu_cube_cs_resolve
// Brief  : Registers p = s + 2c of the add tree and extends it to the acc width.
// Rev    : 1.0 - initial release
// ============================================================================
module npu_cube_cs_resolve #(
    parameter int DWOUPUT = npu_cube_pkg::DWOUPUT,
    parameter int DWACC   = npu_cube_pkg::DWACC
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                i_vld,
    input  wire [DWOUPUT-1:0]  i_result_s,
    input  wire [DWOUPUT-1:0]  i_result_c,
    input  wire                i_is_signed,
    output logic               o_vld,
    output logic [DWACC-1:0]   o_p_ext
);
    logic [DWOUPUT-1:0] w_p;
    logic [DWOUPUT-1:0] r_p;
    logic               r_vld;

    // Carry vector is weighted by two; the top carry bit falls off the tree width.
    assign w_p = i_result_s + (i_result_c << 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_p <= w_p;
            end
        end
    end

    assign o_vld = r_vld;

    generate
        if (DWACC > DWOUPUT) begin : g_ext
            assign o_p_ext = {{(DWACC-DWOUPUT){i_is_signed & r_p[DWOUPUT-1]}}, r_p};
        end else begin : g_trunc
            assign o_p_ext = r_p[DWACC-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/npu_cube_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : npu_cube_acc_ctrl
// Brief  : Job sequencer feeding the cube add tree and accumulating its results.
// Rev    : 1.0 - initial release
// ============================================================================
module npu_cube_acc_ctrl #(
    parameter int DWA              = npu_cube_pkg::DWA,
    parameter int DWB_CODE         = npu_cube_pkg::DWB_CODE,
    parameter int NPU_CUBE_MAC_NUM = npu_cube_pkg::NPU_CUBE_MAC_NUM,
    parameter int DWOUPUT          = npu_cube_pkg::DWOUPUT,
    parameter int DWACC            = npu_cube_pkg::DWACC,
    parameter int DWLEN            = npu_cube_pkg::DWLEN
) (
    input  wire                 clk,
    input  wire                 rst_n,
    npu_cube_acc_ctrl_if.slave  bus
);
    import npu_cube_pkg::*;

    logic [STATE_W-1:0]                   r_state;
    logic [DWLEN-1:0]                     r_len;
    logic [DWLEN-1:0]                     r_cnt;
    logic                                 r_signed;
    logic [DWA*NPU_CUBE_MAC_NUM-1:0]      r_tree_data;
    logic [DWB_CODE*NPU_CUBE_MAC_NUM-1:0] r_tree_code;
    logic                                 r_s0_vld;
    logic [DWACC-1:0]                     r_acc;
    logic                                 r_ovf;

    logic                                 w_in_ready;
    logic                                 w_accept;
    logic [DWLEN-1:0]                     w_cnt_nxt;
    logic                                 w_last_beat;
    logic                                 w_p_vld;
    logic [DWACC-1:0]                     w_p_ext;
    logic [DWACC:0]                       w_sum;
    logic                                 w_add_ovf;
    logic                                 w_last_acc;

    npu_cube_cs_resolve #(
        .DWOUPUT (DWOUPUT),
        .DWACC   (DWACC)
    ) u_cs_resolve (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vld       (r_s0_vld),
        .i_result_s  (bus.tree_result_s),
        .i_result_c  (bus.tree_result_c),
        .i_is_signed (r_signed),
        .o_vld       (w_p_vld),
        .o_p_ext     (w_p_ext)
    );

    assign w_in_ready  = (r_state == ST_RUN) && (r_cnt < r_len);
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_cnt_nxt   = r_cnt + {{(DWLEN-1){1'b0}}, 1'b1};
    assign w_last_beat = w_accept && (w_cnt_nxt == r_len);

    assign w_sum     = {1'b0, r_acc} + {1'b0, w_p_ext};
    assign w_add_ovf = r_signed ? ((r_acc[DWACC-1] == w_p_ext[DWACC-1]) &&
                                   (w_sum[DWACC-1] != r_acc[DWACC-1]))
                                : w_sum[DWACC];

    // Beats leave the pipeline in order, so once S0 is empty in DRAIN the
    // accumulate in flight is the job's last one.
    assign w_last_acc = (r_state == ST_DRAIN) && w_p_vld && !r_s0_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_signed    <= 1'b0;
            r_tree_data <= '0;
            r_tree_code <= '0;
            r_s0_vld    <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_s0_vld <= w_accept;
            if (w_accept) begin
                r_cnt       <= w_cnt_nxt;
                r_tree_data <= bus.in_data;
                r_tree_code <= bus.in_para_code;
            end
            if (w_p_vld) begin
                r_acc <= w_sum[DWACC-1:0];
                r_ovf <= r_ovf | w_add_ovf;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.cfg_start) begin
                        r_len    <= bus.cfg_len;
                        r_signed <= bus.cfg_signed;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_ovf    <= 1'b0;
                        r_state  <= (bus.cfg_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_last_beat) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_acc) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cfg_busy       = (r_state != ST_IDLE);
    assign bus.in_ready       = w_in_ready;
    assign bus.tree_data      = r_tree_data;
    assign bus.tree_para_code = r_tree_code;
    assign bus.tree_is_signed = r_signed;
    assign bus.out_valid      = (r_state == ST_DONE);
    assign bus.out_acc        = r_acc;
    assign bus.out_ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_npu_cube_acc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_npu_cube_acc_ctrl
// Brief  : Scoreboard bench for the cube accumulator at 32- and 20-bit acc width.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_npu_cube_acc_ctrl;

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
        int          rise;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q32[$];
    exp_t q20[$];
    logic pv32 = 1'b0;
    logic pv20 = 1'b0;
    logic [18:0] stub_c = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    npu_cube_acc_ctrl_if bus ();
    npu_cube_acc_ctrl_if #(.DWACC(20)) bus20 ();

    npu_cube_acc_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    npu_cube_acc_ctrl #(.DWACC(20)) u_dut20 (.clk(clk), .rst_n(rst_n), .bus(bus20));

    assign bus20.cfg_start    = bus.cfg_start;
    assign bus20.cfg_len      = bus.cfg_len;
    assign bus20.cfg_signed   = bus.cfg_signed;
    assign bus20.in_valid     = bus.in_valid;
    assign bus20.in_data      = bus.in_data;
    assign bus20.in_para_code = bus.in_para_code;
    assign bus20.out_ready    = bus.out_ready;

    // Dot product of one beat, reduced mod 2^19 and read back as the tree would.
    function automatic longint beat_p(input logic [63:0] d, input logic [95:0] c, input logic sg);
        longint s, a, b;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            a = sg ? longint'($signed(d[i*8 +: 8]))   : longint'(d[i*8 +: 8]);
            b = sg ? longint'($signed(c[i*12 +: 12])) : longint'(c[i*12 +: 12]);
            s += a * b;
        end
        s = s & ((longint'(1) << 19) - 1);
        if (sg && s >= (longint'(1) << 18)) s -= (longint'(1) << 19);
        return s;
    endfunction

    // Tree stub: random carry each cycle, sum compensates so s + 2c is the dot.
    always @(negedge clk) stub_c <= 19'($urandom);
    assign bus.tree_result_c   = stub_c;
    assign bus.tree_result_s   = 19'(beat_p(bus.tree_data, bus.tree_para_code, bus.tree_is_signed)) - (stub_c << 1);
    assign bus20.tree_result_c = stub_c;
    assign bus20.tree_result_s = 19'(beat_p(bus20.tree_data, bus20.tree_para_code, bus20.tree_is_signed)) - (stub_c << 1);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic acc_add(input int w, input logic sg, input longint p, inout longint a, inout logic ovf);
        longint m, t;
        m = longint'(1) << w;
        t = a + p;
        if (sg) begin
            if (t >= m / 2 || t < -(m / 2)) begin
                ovf = 1'b1;
                t = (t < 0) ? t + m : t - m;
            end
        end else if (t >= m) begin
            ovf = 1'b1;
            t = t - m;
        end
        a = t;
    endtask

    task automatic mon_one(input int w, input logic v, input logic r, input logic [31:0] acc,
                           input logic ovf, input logic pv);
        exp_t e;
        int   sz;
        if (!v) return;
        if (w == 32) sz = q32.size(); else sz = q20.size();
        if (sz == 0) begin
            chk($sformatf("w%0d_unexpected_out_valid", w), 64'd1, 64'd0);
            return;
        end
        if (w == 32) e = q32[0]; else e = q20[0];
        if (!pv) chk($sformatf("w%0d_out_valid_rise_cycle", w), 64'(cyc), 64'(e.rise));
        chk($sformatf("w%0d_out_acc", w), 64'(acc), 64'(e.acc));
        chk($sformatf("w%0d_out_ovf", w), 64'(ovf), 64'(e.ovf));
        if (r) begin
            if (w == 32) void'(q32.pop_front()); else void'(q20.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_one(32, bus.out_valid, bus.out_ready, bus.out_acc, bus.out_ovf, pv32);
            mon_one(20, bus20.out_valid, bus20.out_ready, {12'd0, bus20.out_acc}, bus20.out_ovf, pv20);
        end
        pv32 = bus.out_valid;
        pv20 = bus20.out_valid;
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"},      64'(bus.out_valid), 64'd0);
        chk({tag, "_out_acc"},        64'(bus.out_acc), 64'd0);
        chk({tag, "_out_ovf"},        64'(bus.out_ovf), 64'd0);
        chk({tag, "_cfg_busy"},       64'(bus.cfg_busy), 64'd0);
        chk({tag, "_in_ready"},       64'(bus.in_ready), 64'd0);
        chk({tag, "_tree_data"},      bus.tree_data, 64'd0);
        chk({tag, "_tree_code_or"},   64'(|bus.tree_para_code), 64'd0);
        chk({tag, "_tree_is_signed"}, 64'(bus.tree_is_signed), 64'd0);
        chk({tag, "_w20_out_acc"},    64'(bus20.out_acc), 64'd0);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            if (!bus.cfg_busy) return;
            @(posedge clk); #1;
        end
        chk("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    // pat: 0 random, 1 all 255, 2 data -128 / weight 127. abort_at>0 resets after that many beats.
    task automatic run_job(input int len, input logic sg, input int pat, input int vprob, input int abort_at);
        logic [63:0] bd [16];
        logic [95:0] bc [16];
        longint a32, a20, p;
        logic   o32, o20, v, took;
        int     idx, last, start_cyc;
        exp_t   e32, e20;

        for (int i = 0; i < len; i++) begin
            for (int l = 0; l < 8; l++) begin
                case (pat)
                    1:       begin bd[i][l*8 +: 8] = 8'hFF; bc[i][l*12 +: 12] = 12'd255; end
                    2:       begin bd[i][l*8 +: 8] = 8'h80; bc[i][l*12 +: 12] = 12'd127; end
                    default: begin bd[i][l*8 +: 8] = 8'($urandom); bc[i][l*12 +: 12] = 12'($urandom); end
                endcase
            end
        end
        a32 = 0; a20 = 0; o32 = 1'b0; o20 = 1'b0;
        for (int i = 0; i < len; i++) begin
            p = beat_p(bd[i], bc[i], sg);
            acc_add(32, sg, p, a32, o32);
            acc_add(20, sg, p, a20, o20);
        end
        e32.acc = 32'(a32);
        e32.ovf = o32;
        e20.acc = 32'(a20 & ((longint'(1) << 20) - 1));
        e20.ovf = o20;

        wait_idle();
        bus.cfg_start  = 1'b1;
        bus.cfg_len    = 16'(len);
        bus.cfg_signed = sg;
        bus.in_valid   = (len == 0);
        if (len == 0) begin
            e32.rise = cyc + 1;
            e20.rise = cyc + 1;
            q32.push_back(e32);
            q20.push_back(e20);
        end
        @(posedge clk); #1;
        start_cyc     = cyc;
        bus.cfg_start = 1'b0;

        if (len == 0) begin
            for (int t = 0; t < 3; t++) begin
                @(negedge clk);
                chk("zero_len_in_ready", 64'(bus.in_ready), 64'd0);
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            return;
        end

        idx  = 0;
        last = -1;
        for (int t = 0; t < 400 && idx < len; t++) begin
            v = ($urandom_range(0, 99) < vprob);
            bus.in_valid     = v;
            bus.in_data      = v ? bd[idx] : {$urandom, $urandom};
            bus.in_para_code = v ? bc[idx] : {$urandom, $urandom, $urandom};
            @(negedge clk);
            chk("tree_is_signed_in_job", 64'(bus.tree_is_signed), 64'(sg));
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) begin
                idx++;
                if (abort_at > 0 && idx == abort_at) begin
                    bus.in_valid = 1'b0;
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    check_reset_state("abort");
                    return;
                end
                if (idx == len) last = cyc;
            end
        end
        bus.in_valid = 1'b0;
        if (idx != len) begin
            chk("beats_accepted_timeout", 64'(idx), 64'(len));
            return;
        end
        if (vprob >= 100) chk("no_bubble_last_accept_cycle", 64'(last), 64'(start_cyc + len));
        e32.rise = last + 2;
        e20.rise = last + 2;
        q32.push_back(e32);
        q20.push_back(e20);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bool_init();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;

        run_job(4, 1'b0, 1, 100, 0);
        run_job(3, 1'b1, 2, 100, 0);
        run_job(0, 1'b0, 0, 100, 0);

        // Output stall with random input gaps, plus a start request during DONE.
        bus.out_ready = 1'b0;
        run_job(6, 1'($urandom_range(0, 1)), 0, 50, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk);
                seen = bus.out_valid;
            end
            if (!seen) chk("stall_out_valid_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        bus.cfg_start = 1'b1;
        bus.cfg_len   = 16'd3;
        @(posedge clk); #1;
        bus.cfg_start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("start_in_done_out_valid", 64'(bus.out_valid), 64'd1);
        chk("start_in_done_cfg_busy", 64'(bus.cfg_busy), 64'd1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_handshake_idle", 64'(bus.cfg_busy), 64'd0);

        run_job(5, 1'b0, 0, 100, 2);
        run_job(1, 1'b0, 0, 100, 0);

        run_job(3, 1'b0, 1, 100, 0);

        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 8), 1'($urandom_range(0, 1)), 0, 60, 0);
        end

        wait_idle();
        chk("w32_pending_results", 64'(q32.size()), 64'd0);
        chk("w20_pending_results", 64'(q20.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    task automatic bool_init();
        bus.cfg_start    = 1'b0;
        bus.cfg_len      = '0;
        bus.cfg_signed   = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_para_code = '0;
        bus.out_ready    = 1'b1;
    endtask

endmodule
`default_nettype wire
